tribus_arbiter: RTL and testbench
=================================

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shared bus data width.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the captures allowed per grant before forced rotation when the other master is waiting; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports req0, req1  input  1 each  bus requests from master 0 and master 1.
REQ-006 The block SHALL have ports gnt0, gnt1  output  1 each  registered tri-state enables to master 0 and master 1.
REQ-007 The block SHALL have port bus_in  input  WIDTH  resolved shared bus value, which may carry x/z.
REQ-008 The block SHALL have port out_data  output  WIDTH  captured bus word.
REQ-009 The block SHALL have port out_src  output  1  index of the master that drove out_data.
REQ-010 The block SHALL have ports out_valid  output  1  and out_ready  input  1, forming a valid/ready handshake toward the consumer.
REQ-011 The block SHALL have port err  output  1, a one-cycle pulse on a bad capture.
REQ-012 The block SHALL have port err_cnt  output  8, a saturating count of bad captures.

Function
REQ-013 The FSM SHALL have states IDLE, GNT0, GNT1 and TURN; gnt0=1 only in GNT0, gnt1=1 only in GNT1, and gnt0&gnt1 SHALL never be 1.
REQ-014 From IDLE or TURN: if one request is high, the FSM SHALL go to that master's GNT state; if both are high, it SHALL go to the master other than last_owner; if none is high, it SHALL go to IDLE.
REQ-015 Grant latency SHALL be one cycle: a request sampled high at edge N in IDLE gives gnt high from edge N+1.
REQ-016 In GNTx, a capture SHALL occur at a clock edge when gnt is high, reqx is high, and (!out_valid | out_ready); a capture loads out_data<=bus_in and out_src<=x, sets out_valid, and increments burst_cnt.
REQ-017 out_valid SHALL clear on an edge where out_ready=1 and no new capture occurs; a simultaneous capture and accept SHALL keep out_valid=1 with the new data.
REQ-018 In GNTx, when reqx is low, the FSM SHALL go to TURN and the bus SHALL not be sampled in that cycle.
REQ-019 In GNTx, when burst_cnt reaches MAX_BURST and the other request is high, the FSM SHALL go to TURN; if the other request is low, the grant SHALL continue and burst_cnt SHALL hold at MAX_BURST.
REQ-020 Backpressure (out_valid=1, out_ready=0) SHALL hold the grant with no capture and no burst_cnt change.
REQ-021 On entry to GNTx, last_owner SHALL be set to x and burst_cnt cleared; TURN SHALL last exactly one cycle with both gnts low (bus turnaround).
REQ-022 err_cnt SHALL saturate at 8'hFF, and err SHALL still pulse at saturation.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set gnt0=gnt1=0, out_valid=0, out_data=0, out_src=0, err=0, err_cnt=0, burst_cnt=0 and last_owner=1, so that master 0 wins the first tie.
REQ-024 A reset asserted mid-grant or with out_valid=1 SHALL drop the grant and discard the pending word on that edge; outputs SHALL be non-x from the first reset edge.

Configuration
REQ-025 The block SHALL support macro TRIBUS_XCHECK_EN.
REQ-026 With TRIBUS_XCHECK_EN defined, a capture whose bus_in contains any x or z bit (reduction-XOR compared case-equal to 1'bx) SHALL pulse err for one cycle, increment err_cnt, and still capture the word.
REQ-027 Without TRIBUS_XCHECK_EN, err and err_cnt SHALL be constant 0 and no x/z test logic SHALL be present.

Verification
REQ-028 The bench SHALL hold reset 2 cycles, then set req0=1, bus_in=8'hA5 and out_ready=1; gnt0 is required to be high on the next edge and out_data=8'hA5 with out_src=0 and out_valid=1 one edge later.
REQ-029 The bench SHALL raise req0 and req1 simultaneously from IDLE after reset; gnt0 is required first, and after 4 captures TURN is required for 1 cycle, then gnt1, then after 4 more captures gnt0 again.
REQ-030 The bench SHALL run with req1 only and out_ready=0 for 5 cycles; exactly 1 capture is required, out_valid is required to stay 1 and out_data to stay unchanged, and the grant is required to be held; when out_ready is set to 1, captures are required every cycle.
REQ-031 The bench SHALL run with TRIBUS_XCHECK_EN defined and master 0 granted, and drive bus_in=8'bzzzz_0101 for 1 capture; err=1 for 1 cycle and err_cnt=1 are required; 300 bad captures are required to leave err_cnt=8'hFF.
REQ-032 The bench SHALL pull rst_n low for 1 cycle during GNT1 with out_valid=1; IDLE, gnt1=0, out_valid=0, and a master 0 win on the next tie are all required.
REQ-033 The bench SHALL drop req0 mid-burst; gnt0 is required to be low on the next edge, followed by 1 TURN cycle, and no capture is required in the cycle req0 was low.

Source files
------------

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: two-master tri-state bus arbiter with burst rotation and output capture; define TRIBUS_XCHECK_EN to flag x/z captures
module tribus_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [7:0]       err_cnt
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);
  state_t state, state_nx, pick;
  logic last_owner, own_req, oth_req, granted, rotate, cap, entry;
  logic [3:0] burst_cnt;
  always_comb begin
    granted  = state == GNT0 || state == GNT1;
    own_req  = state == GNT0 ? req0 : req1;
    oth_req  = state == GNT0 ? req1 : req0;
    rotate   = granted && burst_cnt == MAX_B && oth_req;
    cap      = granted && own_req && !rotate && (!out_valid || out_ready);
    pick     = req0 && req1 ? (last_owner ? GNT0 : GNT1) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
    state_nx = !granted ? pick : (!own_req || rotate) ? TURN : state;
    entry    = state_nx != state && (state_nx == GNT0 || state_nx == GNT1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      out_data   <= '0;
      out_src    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_nx;
      gnt0  <= state_nx == GNT0;
      gnt1  <= state_nx == GNT1;
      if (entry) begin
        last_owner <= state_nx == GNT1;
        burst_cnt  <= '0;
      end else if (cap && burst_cnt != MAX_B) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
      if (cap) begin
        out_data  <= bus_in;
        out_src   <= state == GNT1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`ifdef TRIBUS_XCHECK_EN
  logic bad;
  assign bad = cap && ((^bus_in) === 1'bx);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= bad;
      if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_tribus_arbiter.sv
// tb_tribus_arbiter: directed checks of grant order, rotation, backpressure, reset and error counting
module tb_tribus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, req0, req1, out_ready;
  logic [7:0] bus_in;
  logic       gnt0, gnt1, out_src, out_valid, err;
  logic [7:0] out_data, err_cnt;
  int n_checks = 0;
  int n_errors = 0;
  tribus_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .bus_in(bus_in), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    out_ready = 1'b0;
    bus_in = 8'h00;
    step();
    step();
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_gnt1", 32'(gnt1), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_src", 32'(out_src), 0);
    check("rst_err", 32'(err), 0);
    check("rst_errcnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    req0 = 1'b1;
    bus_in = 8'hA5;
    out_ready = 1'b1;
    step();
    check("lat_gnt0", 32'(gnt0), 1);
    check("lat_valid", 32'(out_valid), 0);
    step();
    check("cap_data", 32'(out_data), 32'hA5);
    check("cap_src", 32'(out_src), 0);
    check("cap_valid", 32'(out_valid), 1);
    req0 = 1'b0;
    bus_in = 8'h5A;
    step();
    check("drop_gnt0", 32'(gnt0), 0);
    check("drop_gnt1", 32'(gnt1), 0);
    check("drop_nocap", 32'(out_data), 32'hA5);
    check("drop_valid", 32'(out_valid), 0);
    req0 = 1'b1;
    step();
    check("turn1_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    step();
    step();
    check("idle_gnt0", 32'(gnt0), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    check("tie_gnt0", 32'(gnt0), 1);
    check("tie_gnt1", 32'(gnt1), 0);
    for (int i = 0; i < 4; i++) begin
      bus_in = 8'h10 + 8'(i);
      step();
      check("b0_data", 32'(out_data), 32'h10 + i);
      check("b0_src", 32'(out_src), 0);
      check("b0_gnt0", 32'(gnt0), 1);
    end
    bus_in = 8'hEE;
    step();
    check("rot0_gnt0", 32'(gnt0), 0);
    check("rot0_gnt1", 32'(gnt1), 0);
    check("rot0_nocap", 32'(out_data), 32'h13);
    step();
    check("rot0_to_gnt1", 32'(gnt1), 1);
    for (int i = 0; i < 4; i++) begin
      bus_in = 8'h20 + 8'(i);
      step();
      check("b1_data", 32'(out_data), 32'h20 + i);
      check("b1_src", 32'(out_src), 1);
      check("b1_gnt1", 32'(gnt1), 1);
    end
    step();
    check("rot1_gnt0", 32'(gnt0), 0);
    check("rot1_gnt1", 32'(gnt1), 0);
    step();
    check("rot1_to_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    req1 = 1'b1;
    out_ready = 1'b0;
    bus_in = 8'h77;
    step();
    check("bp_gnt1", 32'(gnt1), 1);
    step();
    check("bp_first", 32'(out_data), 32'h77);
    bus_in = 8'h88;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_hold", 32'(out_data), 32'h77);
      check("bp_gnt1", 32'(gnt1), 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_in = 8'h30 + 8'(i);
      step();
      check("flow_data", 32'(out_data), 32'h30 + i);
      check("flow_valid", 32'(out_valid), 1);
      check("flow_gnt1", 32'(gnt1), 1);
    end
    rst_n = 1'b0;
    step();
    check("mid_rst_gnt1", 32'(gnt1), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    req0 = 1'b1;
    step();
    check("post_rst_gnt0", 32'(gnt0), 1);
    check("post_rst_gnt1", 32'(gnt1), 0);
    req1 = 1'b0;
`ifdef TRIBUS_XCHECK_EN
    bus_in = 8'bzzzz_0101;
    step();
    check("x_err", 32'(err), 1);
    check("x_errcnt", 32'(err_cnt), 1);
    check("x_data_lo", 32'(out_data[3:0]), 32'h5);
    bus_in = 8'h05;
    step();
    check("x_err_pulse", 32'(err), 0);
    check("x_errcnt_hold", 32'(err_cnt), 1);
    bus_in = 8'bzzzz_0101;
    repeat (300) step();
    check("x_sat_cnt", 32'(err_cnt), 32'hFF);
    check("x_sat_err", 32'(err), 1);
`else
    bus_in = 8'h05;
    step();
    check("nx_data", 32'(out_data), 32'h05);
    check("nx_err", 32'(err), 0);
    check("nx_errcnt", 32'(err_cnt), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
